branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumes the lt/eq/gt flags produced by the 16-bit magnitude comparator and turns them into the next program counter.
- Holds a flag register written by compare instructions and evaluates branch conditions against it, with same-cycle bypass when a compare and a branch issue together.
- Owns the PC register of the single-cycle datapath.
- Counts taken control transfers for debug.

Parameters:
- PC_W, 16, program counter width in bits.
- OFF_W, 8, width of the two's-complement branch offset.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the taken-transfer counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall, all state held.
- flag_we  in  1  latch lt_in/eq_in/gt_in into the flag register.
- lt_in  in  1  comparator less-than.
- eq_in  in  1  comparator equal.
- gt_in  in  1  comparator greater-than.
- br_valid  in  1  conditional branch this cycle.
- br_cond  in  3  condition code.
- br_off  in  OFF_W  signed branch offset, in words, relative to pc+1.
- jmp_valid  in  1  unconditional absolute jump.
- jmp_addr  in  PC_W  jump target.
- pc  out  PC_W  current PC (registered).
- flags  out  3  flag register, {lt,eq,gt}.
- taken  out  1  registered; 1 for one cycle after a taken branch or jump.
- flag_err  out  1  sticky; set when a non-one-hot flag triple is written.
- taken_cnt  out  CNT_W  saturating count of taken transfers.

Behaviour:
- Reset (rst=1 at a clk edge, overrides everything including en):
  - pc=RESET_PC, flags=3'b010, taken=0, flag_err=0, taken_cnt=0.
  - Reset mid-stall or mid-branch discards the pending transfer.
- Flag register:
  - Updated only when en=1 and flag_we=1, and only if {lt_in,eq_in,gt_in} is one-hot.
  - Otherwise flags hold. If en=1, flag_we=1 and the input is not one-hot, flag_err is set and stays set until rst.
- Effective flags (combinational):
  - Equal to the incoming triple when en=1, flag_we=1 and the input is one-hot (bypass).
  - Otherwise equal to the registered flags.
- Condition decode (cond_true from effective flags):
  - 000 EQ: eq.
  - 001 NE: !eq.
  - 010 LT: lt.
  - 011 GE: gt|eq.
  - 100 GT: gt.
  - 101 LE: lt|eq.
  - 110 ALWAYS: 1.
  - 111 NEVER: 0.
- Next PC, when en=1, evaluated in priority order:
  1. jmp_valid: pc <= jmp_addr. br_valid is ignored.
  2. br_valid & cond_true: pc <= pc + 1 + sext(br_off), truncated mod 2^PC_W. Wrap in both directions is legal and silent.
  3. Otherwise: pc <= pc + 1, wraps from all-ones to 0.
- en=0: pc, flags, taken_cnt and flag_err hold; taken is driven 0 the next cycle; branch and jump inputs are ignored.
- taken is registered: it is 1 in the cycle after a rule-1 or rule-2 transfer. A fall-through branch (condition false) produces taken=0.
- taken_cnt increments on each transfer that sets taken, and saturates at all-ones.
- Latency:
  - Flags are visible on the flags output 1 cycle after the write.
  - Flags are usable by a branch in the same cycle via bypass.
  - The new PC is visible 1 cycle after the transfer.
- br_off=-1 yields pc <= pc, which is the intended self-loop idle.

Test Plan:
- Reset check: assert rst for 2 cycles with en=1 and jmp_valid=1 → pc=0, flags=3'b010, taken=0, taken_cnt=0, flag_err=0. Release rst with en=1 and no branch or jump → pc steps 0,1,2,3.
- Bypass branch: pc=0x0010, flag_we=1 with {lt,eq,gt}=100, br_valid=1, br_cond=010, br_off=0x05 in the same cycle → next pc=0x0016, taken=1, flags=100, taken_cnt=1. Repeat with br_cond=100 (GT) → pc=0x0011, taken=0.
- Backward branch and wrap:
  - flags=010, pc=0x0002, BEQ with br_off=0xF0 (-16) → pc=0xFFF3.
  - pc=0xFFFF, no branch → pc=0x0000.
  - br_off=0xFF (-1) → pc unchanged, taken=1.
- Priority and stall:
  - jmp_valid=1 with jmp_addr=0x1234 plus a true BNE → pc=0x1234.
  - en=0 with jmp_valid=1 for 3 cycles → pc, flags and taken_cnt unchanged, taken=0.
- Bad flags: flag_we=1 with {lt,eq,gt}=110 → flags keep their prior value, flag_err=1, and a same-cycle BLT uses the old flags. flag_err stays 1 through later valid writes and clears only on rst.
- Counter saturation: with CNT_W=4, issue 20 consecutive ALWAYS branches → taken_cnt stops at 15. NEVER branches never increment it.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution and PC sequencing for the single-cycle datapath: flag register
// with same-cycle bypass, condition decode, next-PC selection and a taken counter.
module branch_resolve_unit #(
  parameter int unsigned PC_W = 16,
  parameter int unsigned OFF_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flag_we,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [OFF_W-1:0] br_off,
  input  logic             jmp_valid,
  input  logic [PC_W-1:0]  jmp_addr,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       flags,
  output logic             taken,
  output logic             flag_err,
  output logic [CNT_W-1:0] taken_cnt
);

  // Control inputs are single-cycle qualifiers: br_valid/jmp_valid/flag_we are
  // acted on only in a cycle where en=1; there is no backpressure, so a
  // request presented while en=0 is dropped rather than held.

  logic [2:0]      flag_in;
  logic            in_onehot;
  logic            flag_wr;
  logic            flag_bad;
  logic [2:0]      eff_flags;
  logic            cond_true;
  logic            transfer;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] next_pc;

  assign flag_in   = {lt_in, eq_in, gt_in};
  assign in_onehot = (flag_in == 3'b100) || (flag_in == 3'b010) || (flag_in == 3'b001);
  assign flag_wr   = en & flag_we & in_onehot;
  assign flag_bad  = en & flag_we & ~in_onehot;

  // A valid compare in the same cycle is visible to the branch without waiting.
  assign eff_flags = flag_wr ? flag_in : flags;

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = eff_flags[1];
      3'b001:  cond_true = ~eff_flags[1];
      3'b010:  cond_true = eff_flags[2];
      3'b011:  cond_true = eff_flags[0] | eff_flags[1];
      3'b100:  cond_true = eff_flags[0];
      3'b101:  cond_true = eff_flags[2] | eff_flags[1];
      3'b110:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign pc_inc    = pc + PC_W'(1);
  assign br_target = pc_inc + PC_W'($signed(br_off));
  assign transfer  = jmp_valid | (br_valid & cond_true);

  always_comb begin
    next_pc = pc_inc;
    if (jmp_valid) begin
      next_pc = jmp_addr;
    end else if (br_valid && cond_true) begin
      next_pc = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      flags     <= 3'b010;
      taken     <= 1'b0;
      flag_err  <= 1'b0;
      taken_cnt <= '0;
    end else begin
      taken <= en & transfer;
      if (en) begin
        pc <= next_pc;
        if (flag_wr) begin
          flags <= flag_in;
        end
        if (flag_bad) begin
          flag_err <= 1'b1;
        end
        if (transfer && (taken_cnt != {CNT_W{1'b1}})) begin
          taken_cnt <= taken_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: the driver pushes hand-computed state
// expectations, and an independent monitor pops and compares after each clock edge.
module tb_branch_resolve_unit;

  localparam int PC_W = 16;
  localparam int OFF_W = 8;
  localparam int CNT_W = 4;
  localparam int EXP_W = PC_W + 3 + 1 + 1 + CNT_W;

  logic             clk;
  logic             rst;
  logic             en;
  logic             flag_we;
  logic             lt_in;
  logic             eq_in;
  logic             gt_in;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic [OFF_W-1:0] br_off;
  logic             jmp_valid;
  logic [PC_W-1:0]  jmp_addr;
  logic [PC_W-1:0]  pc;
  logic [2:0]       flags;
  logic             taken;
  logic             flag_err;
  logic [CNT_W-1:0] taken_cnt;

  logic [EXP_W-1:0] exp_q[$];
  int               errors;
  int               checks;

  branch_resolve_unit #(
    .PC_W(PC_W), .OFF_W(OFF_W), .RESET_PC(16'h0000), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flag_we(flag_we),
    .lt_in(lt_in), .eq_in(eq_in), .gt_in(gt_in),
    .br_valid(br_valid), .br_cond(br_cond), .br_off(br_off),
    .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
    .pc(pc), .flags(flags), .taken(taken), .flag_err(flag_err),
    .taken_cnt(taken_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive(input logic r, input logic e, input logic fwe,
                       input logic [2:0] f, input logic bv, input logic [2:0] bc,
                       input logic [OFF_W-1:0] bo, input logic jv,
                       input logic [PC_W-1:0] ja);
    @(negedge clk);
    rst = r; en = e; flag_we = fwe;
    {lt_in, eq_in, gt_in} = f;
    br_valid = bv; br_cond = bc; br_off = bo;
    jmp_valid = jv; jmp_addr = ja;
  endtask

  task automatic expect_state(input logic [PC_W-1:0] x_pc, input logic [2:0] x_fl,
                              input logic x_tk, input logic x_er,
                              input logic [CNT_W-1:0] x_cnt);
    exp_q.push_back({x_pc, x_fl, x_tk, x_er, x_cnt});
  endtask

  task automatic idle(input logic [PC_W-1:0] x_pc, input logic [2:0] x_fl,
                      input logic x_er, input logic [CNT_W-1:0] x_cnt);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 16'h0000);
    expect_state(x_pc, x_fl, 1'b0, x_er, x_cnt);
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [PC_W-1:0] act,
                     input logic [PC_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always begin
    logic [EXP_W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", pc, e[EXP_W-1 -: PC_W]);
      chk("flags", PC_W'(flags), PC_W'(e[CNT_W+2 +: 3]));
      chk("taken", PC_W'(taken), PC_W'(e[CNT_W+1]));
      chk("flag_err", PC_W'(flag_err), PC_W'(e[CNT_W]));
      chk("taken_cnt", PC_W'(taken_cnt), PC_W'(e[CNT_W-1:0]));
    end
  end

  initial begin
    logic [PC_W-1:0] p;
    int              c;
    errors = 0;
    checks = 0;
    rst = 1'b1; en = 1'b1; flag_we = 1'b0;
    lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b0;
    br_valid = 1'b0; br_cond = 3'b000; br_off = '0;
    jmp_valid = 1'b0; jmp_addr = '0;

    // reset overrides a pending jump
    repeat (2) begin
      drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00, 1'b1, 16'h1234);
      expect_state(16'h0000, 3'b010, 1'b0, 1'b0, 4'd0);
    end
    // free-run from 0 up to 0x0010
    for (int i = 1; i <= 16; i++) idle(PC_W'(i), 3'b010, 1'b0, 4'd0);

    // bypass: LT written and used in the same cycle
    drive(1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 3'b010, 8'h05, 1'b0, 16'h0000);
    expect_state(16'h0016, 3'b100, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00, 1'b1, 16'h0010);
    expect_state(16'h0010, 3'b100, 1'b1, 1'b0, 4'd2);
    drive(1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 3'b100, 8'h05, 1'b0, 16'h0000);
    expect_state(16'h0011, 3'b100, 1'b0, 1'b0, 4'd2);

    // backward branch with wrap below zero, then wrap past all-ones
    drive(1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 3'b000, 8'h00, 1'b1, 16'h0002);
    expect_state(16'h0002, 3'b010, 1'b1, 1'b0, 4'd3);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 8'hF0, 1'b0, 16'h0000);
    expect_state(16'hFFF3, 3'b010, 1'b1, 1'b0, 4'd4);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00, 1'b1, 16'hFFFF);
    expect_state(16'hFFFF, 3'b010, 1'b1, 1'b0, 4'd5);
    idle(16'h0000, 3'b010, 1'b0, 4'd5);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 8'hFF, 1'b0, 16'h0000);
    expect_state(16'h0000, 3'b010, 1'b1, 1'b0, 4'd6);

    // jump beats a true BNE (flags bypassed to LT)
    drive(1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 3'b001, 8'h05, 1'b1, 16'h1234);
    expect_state(16'h1234, 3'b100, 1'b1, 1'b0, 4'd7);
    // stall: everything holds, even a bad flag write does not flag an error
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b1, 3'b110, 1'b1, 3'b110, 8'h05, 1'b1, 16'h5555);
      expect_state(16'h1234, 3'b100, 1'b0, 1'b0, 4'd7);
    end
    idle(16'h1235, 3'b100, 1'b0, 4'd7);

    // bad flag write: ignored, sticky error, BLT uses old LT flags
    drive(1'b0, 1'b1, 1'b1, 3'b011, 1'b1, 3'b010, 8'h10, 1'b0, 16'h0000);
    expect_state(16'h1246, 3'b100, 1'b1, 1'b1, 4'd8);
    drive(1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 3'b000, 8'h00, 1'b0, 16'h0000);
    expect_state(16'h1247, 3'b001, 1'b0, 1'b1, 4'd8);

    // NEVER does not count; ALWAYS saturates the 4-bit counter
    p = 16'h1247;
    repeat (2) begin
      p = p + 16'd1;
      drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b111, 8'h05, 1'b0, 16'h0000);
      expect_state(p, 3'b001, 1'b0, 1'b1, 4'd8);
    end
    c = 8;
    for (int i = 0; i < 20; i++) begin
      p = p + 16'd1;
      if (c < 15) c++;
      drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b110, 8'h00, 1'b0, 16'h0000);
      expect_state(p, 3'b001, 1'b1, 1'b1, CNT_W'(c));
    end
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b111, 8'h05, 1'b0, 16'h0000);
    expect_state(16'h125E, 3'b001, 1'b0, 1'b1, 4'd15);

    // reset during stall clears everything including flag_err
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b110, 8'h05, 1'b1, 16'h4321);
    expect_state(16'h0000, 3'b010, 1'b0, 1'b0, 4'd0);
    idle(16'h0001, 3'b010, 1'b0, 4'd0);

    @(negedge clk);
    rst = 1'b0; en = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0; flag_we = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
